// File: rtl/whitening_pkg.sv
// Shared types and arithmetic helpers for the whitening datapath.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package whitening_pkg;

  // Engine sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_ROUND = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  // Working width for the shared round/saturate helper. It must hold the
  // widest accumulator in use (2W+1+clog2(N)), which covers W up to 45 at N=16.
  localparam int WIDE_W = 96;
  typedef logic signed [WIDE_W-1:0] wide_t;

  // Result of round/saturate: value already clipped to W bits, plus a clip flag.
  typedef struct packed {
    wide_t val;
    logic  sat;
  } rnd_t;

  // Accumulator width: a (W x W+1)-bit product is 2W+1 bits, and summing N of
  // them adds clog2(N) bits, so the sum can never overflow.
  function automatic int acc_width(input int w, input int n);
    return 2 * w + 1 + $clog2(n);
  endfunction

  // Unity coefficient in Q(FRAC) format.
  function automatic wide_t one_q(input int frac);
    return wide_t'(1) <<< frac;
  endfunction

  // Largest value representable as a signed w-bit number.
  function automatic wide_t sat_hi(input int w);
    return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
  endfunction

  // Smallest value representable as a signed w-bit number.
  function automatic wide_t sat_lo(input int w);
    return -(wide_t'(1) <<< (w - 1));
  endfunction

  // Drops frac fractional bits, rounding half toward +inf, then clips the
  // result to signed w bits. w and frac are elaboration-time constants at
  // every call site. frac must be at least 1.
  function automatic rnd_t rnd_sat(input wide_t acc, input int w, input int frac);
    wide_t r;
    rnd_t  res;
    r = (acc + (wide_t'(1) <<< (frac - 1))) >>> frac;
    if (r > sat_hi(w)) begin
      res.val = sat_hi(w);
      res.sat = 1'b1;
    end else if (r < sat_lo(w)) begin
      res.val = sat_lo(w);
      res.sat = 1'b1;
    end else begin
      res.val = r;
      res.sat = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/whitening_row_mac.sv
// One output row of Z = V*xc: accumulates coef*xc per cycle, exposes rounded/saturated result.
// Latency: 1 cycle per MAC step; the rounded output is combinational from the accumulator.
// Backpressure: none; the parent sequences clear and enable.
module whitening_row_mac
  import whitening_pkg::*;
#(
  parameter int W     = 26,
  parameter int FRAC  = 14,
  parameter int ACC_W = 55
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  input  logic signed [W-1:0] coef,
  input  logic signed [W:0]   xc,
  output logic signed [W-1:0] z,
  output logic                sat
);

  logic signed [ACC_W-1:0] acc;
  logic signed [2*W:0]     prod;
  rnd_t                    rs;
  logic                    unused_hi;

  assign prod = (2*W+1)'(coef) * (2*W+1)'(xc);

  // Accumulator: cleared on capture, adds one column product per enabled cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

  // Round and clip the accumulated row to the output sample width.
  always_comb begin
    rs  = rnd_sat(wide_t'(acc), W, FRAC);
    z   = rs.val[W-1:0];
    sat = rs.sat;
  end

  // Upper bits are a sign extension of z after clipping.
  assign unused_hi = ^rs.val[WIDE_W-1:W];

endmodule

// File: rtl/whitening_stream_engine.sv
// Streaming whitening Z = V*(X - m) over N channels with double-buffered V/m and atomic commit.
// Latency: N+1 cycles from input accept to Out_valid; one sample every N+2 cycles at best.
// Backpressure: Out_ready low holds Out_data and drops In_ready; a drain may coincide with a new capture.
module whitening_stream_engine
  import whitening_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 26,
  parameter int FRAC  = 14,
  parameter int CNT_W = 16
) (
  input  logic                 CLK_wht,
  input  logic                 RST_wht,
  input  logic                 Coef_we,
  input  logic [$clog2(N)-1:0] Coef_row,
  input  logic [$clog2(N)-1:0] Coef_col,
  input  logic [W-1:0]         Coef_data,
  input  logic                 Mean_we,
  input  logic [$clog2(N)-1:0] Mean_idx,
  input  logic [W-1:0]         Mean_data,
  input  logic                 Coef_commit,
  input  logic                 In_valid,
  output logic                 In_ready,
  input  logic [N*W-1:0]       In_data,
  output logic                 Out_valid,
  input  logic                 Out_ready,
  output logic [N*W-1:0]       Out_data,
  output logic [N-1:0]         Out_sat,
  output logic                 Sat_sticky,
  output logic                 Busy,
  output logic [CNT_W-1:0]     Sample_cnt
);

  localparam int IW    = $clog2(N);
  localparam int ACC_W = acc_width(W, N);
  localparam logic [W-1:0] ONE_Q_W = W'(one_q(FRAC));

  state_t state, state_nx;

  // Active set drives the datapath; shadow set takes runtime writes.
  logic signed [W-1:0] v_act [N][N];
  logic signed [W-1:0] v_sh  [N][N];
  logic signed [W-1:0] m_act [N];
  logic signed [W-1:0] m_sh  [N];
  logic                commit_pend;

  logic signed [W:0]   xc [N];
  logic [IW-1:0]       col;

  logic signed [W-1:0] z_row [N];
  logic [N-1:0]        sat_row;

  logic capture, mac_en, load_out, drain, swap;

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_nx = state;
    In_ready = 1'b0;
    capture  = 1'b0;
    mac_en   = 1'b0;
    load_out = 1'b0;
    drain    = 1'b0;
    case (state)
      ST_IDLE: begin
        In_ready = 1'b1;
        if (In_valid) begin
          capture  = 1'b1;
          state_nx = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        mac_en = 1'b1;
        if (col == IW'(N - 1)) state_nx = ST_ROUND;
      end
      ST_ROUND: begin
        load_out = 1'b1;
        state_nx = ST_HOLD;
      end
      ST_HOLD: begin
        In_ready = Out_ready;
        if (Out_ready) begin
          drain = 1'b1;
          if (In_valid) begin
            capture  = 1'b1;
            state_nx = ST_ACCUM;
          end else begin
            state_nx = ST_IDLE;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    // ACCUM reads V every cycle, and a capture binds the sample to the
    // current set, so the swap waits for any other edge. ROUND only reads
    // the accumulators, so a deferred swap lands on the sample's ROUND edge.
    swap = commit_pend && (state != ST_ACCUM) && !capture;
  end

  assign Busy = (state != ST_IDLE);

  // State register.
  always_ff @(posedge CLK_wht) begin
    if (RST_wht) state <= ST_IDLE;
    else         state <= state_nx;
  end

  // Centre the accepted sample against the active mean and step the column.
  always_ff @(posedge CLK_wht) begin
    if (RST_wht) begin
      col <= '0;
      for (int k = 0; k < N; k++) xc[k] <= '0;
    end else if (capture) begin
      col <= '0;
      for (int k = 0; k < N; k++) begin
        xc[k] <= $signed({In_data[k*W+W-1], In_data[k*W +: W]})
               - $signed({m_act[k][W-1], m_act[k]});
      end
    end else if (mac_en) begin
      col <= col + 1'b1;
    end
  end

  // Shadow writes, pending commit and the shadow-to-active swap.
  always_ff @(posedge CLK_wht) begin
    if (RST_wht) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          v_act[r][c] <= (r == c) ? ONE_Q_W : '0;
          v_sh[r][c]  <= (r == c) ? ONE_Q_W : '0;
        end
        m_act[r] <= '0;
        m_sh[r]  <= '0;
      end
      commit_pend <= 1'b0;
    end else begin
      if (Coef_we) v_sh[Coef_row][Coef_col] <= Coef_data;
      if (Mean_we) m_sh[Mean_idx] <= Mean_data;
      if (swap) begin
        v_act <= v_sh;
        m_act <= m_sh;
      end
      if (Coef_commit)  commit_pend <= 1'b1;
      else if (swap)    commit_pend <= 1'b0;
    end
  end

  // Output register, saturation flags and handshake counter.
  always_ff @(posedge CLK_wht) begin
    if (RST_wht) begin
      Out_valid  <= 1'b0;
      Out_data   <= '0;
      Out_sat    <= '0;
      Sat_sticky <= 1'b0;
      Sample_cnt <= '0;
    end else begin
      if (load_out) begin
        Out_valid <= 1'b1;
        for (int i = 0; i < N; i++) Out_data[i*W +: W] <= z_row[i];
        Out_sat    <= sat_row;
        Sat_sticky <= Sat_sticky | (|sat_row);
      end else if (drain) begin
        Out_valid  <= 1'b0;
        Sample_cnt <= Sample_cnt + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    whitening_row_mac #(
      .W     (W),
      .FRAC  (FRAC),
      .ACC_W (ACC_W)
    ) u_row (
      .clk  (CLK_wht),
      .rst  (RST_wht),
      .clr  (capture),
      .en   (mac_en),
      .coef (v_act[i][col]),
      .xc   (xc[col]),
      .z    (z_row[i]),
      .sat  (sat_row[i])
    );
  end

endmodule

// File: tb/tb_whitening_stream_engine.sv
// Directed bench for whitening_stream_engine at N=4, W=26, FRAC=14.
// Latency: checks N+1-cycle accept-to-valid and back-to-back drain/capture.
// Backpressure: exercises held outputs under Out_ready low and commit timing.
module tb_whitening_stream_engine;

  localparam int N     = 4;
  localparam int W     = 26;
  localparam int FRAC  = 14;
  localparam int CNT_W = 16;
  localparam longint ONE = 16384;

  typedef longint mat_t [16];
  typedef longint vec_t [4];
  typedef struct {
    mat_t       v;
    vec_t       m;
    vec_t       x;
    vec_t       z;
    logic [3:0] sat;
    logic       sticky;
  } rec_t;

  logic           CLK_wht = 1'b0;
  logic           RST_wht = 1'b1;
  logic           Coef_we = 1'b0;
  logic [1:0]     Coef_row = '0;
  logic [1:0]     Coef_col = '0;
  logic [W-1:0]   Coef_data = '0;
  logic           Mean_we = 1'b0;
  logic [1:0]     Mean_idx = '0;
  logic [W-1:0]   Mean_data = '0;
  logic           Coef_commit = 1'b0;
  logic           In_valid = 1'b0;
  logic           In_ready;
  logic [N*W-1:0] In_data = '0;
  logic           Out_valid;
  logic           Out_ready = 1'b1;
  logic [N*W-1:0] Out_data;
  logic [N-1:0]   Out_sat;
  logic           Sat_sticky;
  logic           Busy;
  logic [CNT_W-1:0] Sample_cnt;

  int n_cmp = 0;
  int n_err = 0;
  longint exp_cnt = 0;
  rec_t tbl [5];

  whitening_stream_engine #(.N(N), .W(W), .FRAC(FRAC), .CNT_W(CNT_W)) dut (
    .CLK_wht     (CLK_wht),
    .RST_wht     (RST_wht),
    .Coef_we     (Coef_we),
    .Coef_row    (Coef_row),
    .Coef_col    (Coef_col),
    .Coef_data   (Coef_data),
    .Mean_we     (Mean_we),
    .Mean_idx    (Mean_idx),
    .Mean_data   (Mean_data),
    .Coef_commit (Coef_commit),
    .In_valid    (In_valid),
    .In_ready    (In_ready),
    .In_data     (In_data),
    .Out_valid   (Out_valid),
    .Out_ready   (Out_ready),
    .Out_data    (Out_data),
    .Out_sat     (Out_sat),
    .Sat_sticky  (Sat_sticky),
    .Busy        (Busy),
    .Sample_cnt  (Sample_cnt)
  );

  always #5 CLK_wht = ~CLK_wht;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_wht);
    #1;
  endtask

  function automatic longint ch(input int k);
    return longint'($signed(Out_data[k*W +: W]));
  endfunction

  task automatic set_in(input vec_t x);
    for (int k = 0; k < N; k++) In_data[k*W +: W] = x[k][W-1:0];
  endtask

  task automatic mk_diag(input longint d, output mat_t v);
    for (int i = 0; i < 16; i++) v[i] = ((i / 4) == (i % 4)) ? d : 0;
  endtask

  task automatic write_v(input int r, input int c, input longint val);
    Coef_we   = 1'b1;
    Coef_row  = 2'(r);
    Coef_col  = 2'(c);
    Coef_data = val[W-1:0];
    tick();
    Coef_we   = 1'b0;
  endtask

  // Writes V and m into the shadow (means on the same edges as the first
  // four coefficients), commits, and idles until the swap has happened.
  task automatic load_set(input mat_t v, input vec_t m);
    for (int i = 0; i < 16; i++) begin
      Coef_we   = 1'b1;
      Coef_row  = 2'(i / 4);
      Coef_col  = 2'(i % 4);
      Coef_data = v[i][W-1:0];
      Mean_we   = (i < 4);
      Mean_idx  = 2'(i % 4);
      Mean_data = m[i % 4][W-1:0];
      tick();
    end
    Coef_we     = 1'b0;
    Mean_we     = 1'b0;
    Coef_commit = 1'b1;
    tick();
    Coef_commit = 1'b0;
    tick();
    tick();
  endtask

  task automatic send(input vec_t x);
    int n;
    n = 0;
    while (!In_ready && n < 40) begin
      tick();
      n++;
    end
    set_in(x);
    In_valid = 1'b1;
    tick();
    In_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!Out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic check_out(input string name, input vec_t z);
    for (int k = 0; k < N; k++) check($sformatf("%s_ch%0d", name, k), ch(k), z[k]);
  endtask

  task automatic run_vec(input string name, input vec_t x, input vec_t z, input logic [3:0] sat);
    int lat;
    send(x);
    wait_out(lat);
    check({name, "_latency"}, lat, 5);
    check_out(name, z);
    check({name, "_sat"}, longint'(Out_sat), longint'(sat));
    tick();
    exp_cnt++;
    check({name, "_cnt"}, longint'(Sample_cnt), exp_cnt);
    check({name, "_valid_drop"}, longint'(Out_valid), 0);
  endtask

  initial begin
    mat_t   v_id, v_2, v_half;
    vec_t   m0, xa, za;
    int     lat;
    logic [N*W-1:0] snap;

    m0 = '{0, 0, 0, 0};
    mk_diag(ONE, v_id);
    mk_diag(2 * ONE, v_2);
    mk_diag(ONE / 2, v_half);

    // Reset state
    RST_wht = 1'b1;
    repeat (3) tick();
    RST_wht = 1'b0;
    tick();
    check("rst_out_valid", Out_valid, 0);
    check("rst_in_ready", In_ready, 1);
    check("rst_busy", Busy, 0);
    check("rst_cnt", longint'(Sample_cnt), 0);
    check("rst_out_data_zero", longint'(Out_data == '0), 1);
    check("rst_out_sat", longint'(Out_sat), 0);
    check("rst_sticky", Sat_sticky, 0);

    // Identity straight out of reset, no explicit load
    run_vec("ident_rst", '{100, -200, 300, -400}, '{100, -200, 300, -400}, 4'b0000);

    tbl[0] = '{v: v_id, m: m0, x: '{100, -200, 300, -400},
               z: '{100, -200, 300, -400}, sat: 4'b0000, sticky: 1'b0};
    tbl[1] = '{v: v_2, m: '{10, 10, 10, 10}, x: '{110, 20, 10, 0},
               z: '{200, 20, 0, -20}, sat: 4'b0000, sticky: 1'b0};
    // 0.5*I: 1.5->2, -1.5->-1, 0.5->1, -0.5->0 (half rounds toward +inf)
    tbl[2] = '{v: v_half, m: m0, x: '{3, -3, 1, -1},
               z: '{2, -1, 1, 0}, sat: 4'b0000, sticky: 1'b0};
    // Dense matrix with means: xc = (10,20,30,40)
    tbl[3] = '{v: '{ONE, ONE, 0, 0,
                    0, 0, -ONE, 0,
                    ONE / 2, 0, 0, ONE / 2,
                    -ONE, ONE, ONE, -ONE},
               m: '{1, 2, 3, 4}, x: '{11, 22, 33, 44},
               z: '{30, -30, 25, 0}, sat: 4'b0000, sticky: 1'b0};
    // 2*I saturation: +2^25 clips high, -2^25 exact, -2^25-2 clips low
    tbl[4] = '{v: v_2, m: m0, x: '{16777216, -16777216, 5, -16777217},
               z: '{33554431, -33554432, 10, -33554432}, sat: 4'b1001, sticky: 1'b1};

    for (int t = 0; t < 5; t++) begin
      load_set(tbl[t].v, tbl[t].m);
      run_vec($sformatf("vec%0d", t), tbl[t].x, tbl[t].z, tbl[t].sat);
      check($sformatf("vec%0d_sticky", t), Sat_sticky, tbl[t].sticky);
    end

    // Backpressure: hold for 10 cycles, then drain and capture on one edge
    load_set(v_id, m0);
    Out_ready = 1'b0;
    send('{7, 8, 9, 10});
    wait_out(lat);
    check("bp_latency", lat, 5);
    check_out("bp_first", '{7, 8, 9, 10});
    snap = Out_data;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_data_stable", longint'(Out_data == snap), 1);
      check("bp_in_ready_low", In_ready, 0);
      check("bp_valid_held", Out_valid, 1);
    end
    check("bp_cnt_held", longint'(Sample_cnt), exp_cnt);
    set_in('{1, 2, 3, 4});
    In_valid  = 1'b1;
    Out_ready = 1'b1;
    #1;
    check("bp_in_ready_follows", In_ready, 1);
    tick();
    In_valid = 1'b0;
    exp_cnt++;
    check("bp_drain_cnt", longint'(Sample_cnt), exp_cnt);
    check("bp_drain_valid", Out_valid, 0);
    check("bp_recapture_busy", Busy, 1);
    wait_out(lat);
    check("bp_second_latency", lat, 5);
    check_out("bp_second", '{1, 2, 3, 4});
    tick();
    exp_cnt++;

    // Commit during ACCUM; shadow write lands on the swap (ROUND) edge
    for (int k = 0; k < N; k++) write_v(k, k, 2 * ONE);
    set_in('{50, 60, 70, 80});
    In_valid = 1'b1;
    tick();                      // E0: accept with identity active
    In_valid = 1'b0;
    check("cm_accum_busy", Busy, 1);
    tick();                      // E1
    Coef_commit = 1'b1;
    tick();                      // E2: commit pending
    Coef_commit = 1'b0;
    tick();                      // E3
    tick();                      // E4: last MAC
    Coef_we   = 1'b1;
    Coef_row  = 2'd0;
    Coef_col  = 2'd0;
    Coef_data = W'(3 * ONE);
    tick();                      // E5: round and swap
    Coef_we = 1'b0;
    check("cm_inflight_valid", Out_valid, 1);
    check_out("cm_inflight_old_v", '{50, 60, 70, 80});
    tick();
    exp_cnt++;
    run_vec("cm_new_v", '{50, 60, 70, 80}, '{100, 120, 140, 160}, 4'b0000);
    Coef_commit = 1'b1;
    tick();
    Coef_commit = 1'b0;
    tick();
    tick();
    run_vec("cm_late_write", '{50, 60, 70, 80}, '{150, 120, 140, 160}, 4'b0000);

    // Reset during ACCUM discards the sample and restores identity
    send('{100, -200, 300, -400});
    tick();
    tick();
    RST_wht = 1'b1;
    tick();
    RST_wht = 1'b0;
    exp_cnt = 0;
    check("mrst_out_valid", Out_valid, 0);
    check("mrst_in_ready", In_ready, 1);
    check("mrst_busy", Busy, 0);
    check("mrst_cnt", longint'(Sample_cnt), 0);
    check("mrst_sticky", Sat_sticky, 0);
    xa = '{100, -200, 300, -400};
    za = '{100, -200, 300, -400};
    run_vec("mrst_ident", xa, za, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/whitening_stream_engine.md
# whitening_stream_engine

Parametrised streaming whitening engine: Z = V·(X − m) for N channels of signed W-bit fixed-point data. Sits after the covariance/QR/eigen-conditioning chain and replaces the fixed 4-channel second whitening multiplier. It holds V and m in double-buffered registers with runtime load and atomic commit, and adds valid/ready handshaking on both the input and output streams. Outputs are rounded and saturated.

## Interface
Parameters:
- N, 4, channel count (2..16)
- W, 26, sample/coefficient width, signed two's complement
- FRAC, 14, fractional bits of V (1.0 = 2^FRAC)
- CNT_W, 16, width of sample counter

Ports:
- CLK_wht  in  1  sole clock, rising edge
- RST_wht  in  1  reset, synchronous, active-high
- Coef_we  in  1  write V_shadow[Coef_row][Coef_col] <= Coef_data
- Coef_row  in  clog2(N)  row index
- Coef_col  in  clog2(N)  column index
- Coef_data  in  W  coefficient
- Mean_we  in  1  write m_shadow[Mean_idx] <= Mean_data
- Mean_idx  in  clog2(N)  mean index
- Mean_data  in  W  mean value
- Coef_commit  in  1  pulse: copy shadow V and m to the active set
- In_valid  in  1  input sample valid
- In_ready  out  1  engine accepts a sample
- In_data  in  N*W  channel k at bits [k*W +: W]
- Out_valid  out  1  Out_data valid
- Out_ready  in  1  downstream accepts
- Out_data  out  N*W  Z, same packing
- Out_sat  out  N  per-channel saturation for the current Out_data
- Sat_sticky  out  1  OR of every Out_sat ever emitted; cleared only by reset
- Busy  out  1  state ≠ IDLE
- Sample_cnt  out  CNT_W  completed output handshakes; wraps

## Operation
- States: IDLE, ACCUM, ROUND, HOLD.
- IDLE: In_ready=1. When In_valid is high, the engine captures xc[k] = In_data[k] − m_act[k] as W+1 bits, clears the accumulators, sets col=0 and moves to ACCUM.
- ACCUM: each edge performs acc[i] += V_act[i][col]·xc[col] for all rows i in parallel, then col++. After col=N−1 the engine moves to ROUND.
- ROUND: Out_data[i] = sat_W((acc[i] + 2^(FRAC−1)) >>> FRAC), rounding half toward +∞. Out_sat[i] is set if clipping occurred. Out_valid is set and the engine moves to HOLD.
- HOLD: Out_valid=1 and In_ready=Out_ready.
  - If Out_ready is high: Sample_cnt++ and Out_valid drops. If In_valid is also high, a new sample is captured (→ACCUM); otherwise the engine goes to IDLE.
  - If Out_ready is low, Out_data stays stable.
- Widths: the product is 2W+1 bits; ACC_W = 2W+1+clog2(N). The accumulator never overflows. Saturation bounds are −2^(W−1) and 2^(W−1)−1.
- Shadow writes are accepted in any state. Coef_we and Mean_we may occur on the same edge.
- Commit:
  - Coef_commit sets commit_pend.
  - The swap happens on the first edge where the state is IDLE, or HOLD with no new capture on that edge. If a capture happens on that edge, the swap is deferred until that sample leaves ROUND.
  - A sample in flight always uses the set that was active when it was captured.
  - The swap copies the shadow contents as they were before that edge. A shadow write on the swap edge lands only in the shadow.
- Reset: active and shadow V = identity (diagonal 2^FRAC), m = 0, commit_pend=0, state IDLE. All outputs are 0 except In_ready=1. Asserting reset mid-sample discards the sample.

## Timing
- With the accept edge as E0: ACCUM runs on E1..EN, ROUND on E(N+1), and Out_valid is high after E(N+1). Latency is N+1 cycles (5 for N=4).
- Minimum sample period is N+2 cycles (6 for N=4), reached when Out_ready=1.
- In_ready is combinational from state and Out_ready. There is no combinational path from In_valid to Out_*.
- Out_data, Out_sat and Out_valid are registered.

## Structure
- Package whitening_pkg holds: the state encoding, the ACC_W derivation, the ONE_Q constant (2^FRAC), the saturation bounds, and a round/saturate function shared with the covariance path.
- One sub-module, whitening_row_mac, instantiated N times. It contains a single-row accumulator with clear, MAC enable and round/sat output.

## Test plan
- Identity after reset, N=4: input (100, −200, 300, −400) → output (100, −200, 300, −400) with Out_valid exactly 5 cycles after accept, Out_sat=0.
- Load V=2.0·I (0x8000), m=(10,10,10,10), then commit: input (110, 20, 10, 0) → output (200, 20, 0, −20).
- Saturation: V=I·2.0 and input 2^24 → channel outputs 2^25−1, Out_sat bit set, Sat_sticky=1.
- Backpressure: hold Out_ready=0 for 10 cycles → Out_data stable and In_ready=0. Release with In_valid=1 → drain and capture on the same edge, Sample_cnt +1.
- Commit during ACCUM: the sample in flight uses the old V; the next sample uses the new V. A shadow write on the swap edge does not appear in the active set.
- Reset asserted during ACCUM → next cycle Out_valid=0, In_ready=1, V reverts to identity, Sample_cnt=0.
